serial_sub: RTL and testbench
=============================

Name: serial_sub

Overview:
- Bit-serial subtractor: computes diff = a_in - b_in on WIDTH-bit operands, LSB first, one bit per clock.
- Uses a single full-subtractor cell and a borrow flop.
- Counterpart of the arithmetic adder blocks in the ADIC set.
- Sits behind a start/done handshake so a controller can issue operands and collect the difference, borrow and signed-overflow flags.

Parameters:
- WIDTH, 8, operand and result width in bits (legal: 2..32).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  minuend; captured on an accepted start.
- b_in  input  WIDTH  subtrahend; captured on an accepted start.
- busy  output  1  high in SHIFT and DONE states.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- bout  output  1  final borrow; 1 iff a < b unsigned.
- ovf  output  1  signed overflow of a - b (two's complement).

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high, rst.
- Reset (any time, including mid-operation) forces:
  - state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0.
  - Internal shift registers, borrow flop and bit counter cleared.
  - A partial result is discarded.
- States: IDLE, SHIFT, DONE; 2-bit binary encoding IDLE=0, SHIFT=1, DONE=2. Code 3 is illegal and returns to IDLE on the next edge.
- IDLE:
  - start=1 at edge k: load a_sr=a_in, b_sr=b_in, borrow=0, cnt=0; go to SHIFT.
  - start=0: stay.
  - diff/bout/ovf hold their last values.
- SHIFT, each edge:
  - d = a_sr[0]^b_sr[0]^borrow.
  - borrow_next = (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&borrow).
  - Shift d into the result register MSB-side (shift right); shift a_sr and b_sr right by 1; cnt++.
- Leaving SHIFT: on the edge where cnt==WIDTH-1 (the WIDTH-th SHIFT edge, edge k+WIDTH), go to DONE and register:
  - diff = final result.
  - bout = borrow_next.
  - ovf = (a[W-1] ^ b[W-1]) & (a[W-1] ^ diff[W-1]), from the captured operand sign bits.
- DONE:
  - done=1 for exactly this one cycle; next edge goes to IDLE.
- Latency: start accepted at edge k → done high in the cycle after edge k+WIDTH. Next start is accepted at edge k+WIDTH+2 at the earliest.
- start while busy (SHIFT or DONE) is ignored, with no queuing; a_in/b_in changes while busy have no effect.
- Results remain stable from DONE until the next accepted start. They are then overwritten at the end of that operation, not cleared at start.
- Widths: counter width = clog2(WIDTH); all arithmetic is modulo 2^WIDTH.

Decomposition:
- Shared include file (adic_defs.vh): state encodings S_IDLE/S_SHIFT/S_DONE and the default WIDTH.
- One natural sub-module: fs_bit, a combinational full subtractor with inputs a, b, bin and outputs d, bout. It is instantiated once in the datapath.

Test Plan:
- WIDTH=8, a=5, b=3, start one cycle → done 9 cycles after the start edge; diff=0x02, bout=0, ovf=0.
- a=3, b=5 → diff=0xFE, bout=1, ovf=0; a=0, b=0 → diff=0x00, bout=0, ovf=0.
- a=0x80, b=0x01 → diff=0x7F, bout=0, ovf=1; a=0x7F, b=0xFF → diff=0x80, bout=1, ovf=1.
- Start a=9, b=4, then pulse start with a=1, b=1 during SHIFT and during DONE → both ignored; single done pulse, diff=0x05; busy low for exactly 1 cycle before the next accepted start.
- Assert rst 3 cycles into SHIFT → all outputs 0 asynchronously, state IDLE; a fresh start a=0xAA, b=0x55 → diff=0x55, bout=0, ovf=1.
- Random 500 operand pairs against the reference model {bout,diff} = {1'b0,a} - {1'b0,b}, with back-to-back starts.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the serial subtractor: controller state encoding and default width.
package serial_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_fs_bit.sv
// Combinational one-bit full subtractor: d = a - b - bin, bout = borrow out.
module fs_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor, LSB first, one bit per clock, behind a start/done handshake.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             borrow;
  logic             borrow_next;
  logic             d;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;

  fs_bit u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .d    (d),
    .bout (borrow_next)
  );

  assign res_next = {d, res[WIDTH-1:1]};

  // Operand sign bits are kept apart because a_sr/b_sr are consumed by the shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= a_in;
            b_sr   <= b_in;
            a_msb  <= a_in[WIDTH-1];
            b_msb  <= b_in[WIDTH-1];
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res    <= res_next;
          borrow <= borrow_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff  <= res_next;
            bout  <= borrow_next;
            ovf   <= (a_msb ^ b_msb) & (a_msb ^ d);
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=8) against an arithmetic reference model.
module tb_serial_sub;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int compared   = 0;
  int mismatched = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Reference: unsigned difference with borrow, signed overflow from integer range.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] t;
    int sa, sb, r;
    logic o;
    t  = {1'b0, a} - {1'b0, b};
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = sa - sb;
    o  = (r > 127) || (r < -128);
    return {o, t};
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit b2b, input string tag);
    int edges = 0;
    int lat   = 0;
    bit got   = 0;
    logic [W+1:0] exp;
    exp   = model(a, b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    while (!got && edges < 8) begin
      @(posedge clk); #1;
      edges++;
      if (busy) got = 1;
    end
    start = 1'b0;
    compared++;
    if (!got) begin
      mismatched++;
      $display("FAIL %s accept: busy never rose within %0d edges", tag, edges);
      return;
    end
    compared++;
    if (edges != (b2b ? 2 : 1)) begin
      mismatched++;
      $display("FAIL %s accept_edges: got %0d required %0d", tag, edges, b2b ? 2 : 1);
    end
    got = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      a_in = W'($urandom);
      b_in = W'($urandom);
      if (done) got = 1;
    end
    compared++;
    if (lat != W + 1) begin
      mismatched++;
      $display("FAIL %s latency: got %0d required %0d", tag, lat, W + 1);
    end
    compared++;
    if ({ovf, bout, diff} !== exp) begin
      mismatched++;
      $display("FAIL %s result a=%h b=%h: got ovf=%b bout=%b diff=%h required ovf=%b bout=%b diff=%h",
               tag, a, b, ovf, bout, diff, exp[W+1], exp[W], exp[W-1:0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if ({busy, done, bout, ovf, diff} !== '0) begin
      mismatched++;
      $display("FAIL reset: got busy=%b done=%b bout=%b ovf=%b diff=%h required all 0",
               busy, done, bout, ovf, diff);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [6] = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h7F, 8'hC3};
    logic [W-1:0] vb [6] = '{8'h03, 8'h05, 8'h00, 8'h01, 8'hFF, 8'h3C};
    logic [W-1:0] held;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      run_op(va[i], vb[i], 1'b0, "directed");
      held = diff;
      @(negedge clk);
      compared++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        mismatched++;
        $display("FAIL directed pulse: got done=%b busy=%b required 0 0", done, busy);
      end
      repeat (2) @(negedge clk);
      compared++;
      if (diff !== held) begin
        mismatched++;
        $display("FAIL directed hold: got diff=%h required %h", diff, held);
      end
    end
    // Next start must not clear the held result while the operation runs.
    held = diff;
    a_in = 8'h10; b_in = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (diff !== held) begin
      mismatched++;
      $display("FAIL start_no_clear: got diff=%h required %h", diff, held);
    end
    repeat (8) @(negedge clk);
    compared++;
    if (diff !== 8'h0F) begin
      mismatched++;
      $display("FAIL start_no_clear result: got diff=%h required 0f", diff);
    end
  endtask

  task automatic test_ignore_busy();
    int pulses = 0;
    int n = 0;
    @(negedge clk);
    a_in = 8'd9; b_in = 8'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (n < 14) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (done) begin
        pulses++;
        start = 1'b1; a_in = 8'd1; b_in = 8'd1;
      end else if (n >= 2 && n <= 4) begin
        start = 1'b1; a_in = 8'd1; b_in = 8'd1;
      end
    end
    start = 1'b0;
    compared++;
    if (pulses != 1) begin
      mismatched++;
      $display("FAIL ignore_busy pulses: got %0d required 1", pulses);
    end
    compared++;
    if (diff !== 8'h05 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL ignore_busy result: got diff=%h busy=%b required 05 0", diff, busy);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    a_in = 8'h3C; b_in = 8'h11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({busy, done, bout, ovf, diff} !== '0) begin
      mismatched++;
      $display("FAIL mid_reset: got busy=%b done=%b bout=%b ovf=%b diff=%h required all 0",
               busy, done, bout, ovf, diff);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(8'hAA, 8'h55, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    run_op(W'($urandom), W'($urandom), 1'b0, "random_first");
    for (int i = 1; i < 500; i++)
      run_op(W'($urandom), W'($urandom), 1'b1, "random_b2b");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_busy();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
